counter_wrap_logger: RTL and testbench
======================================

# counter_wrap_logger

Downstream consumer of the 4-bit up-counter stage. It watches the counter value and its overflow flag and detects every wrap (all-ones to zero). For each wrap it builds a timestamped event record and buffers it in a small FIFO, which drains through a valid/ready stream. It also raises a sticky interrupt on each wrap and on each overflow-flag rise, for the control/status block.

## Interface
- CNT_W, 4, width of observed counter value
- TS_W, 16, width of free-running timestamp
- WRAP_W, 8, width of wrap sequence number
- DEPTH, 4, event FIFO depth (power of two, ≥2)
- clk  in  1  clock; all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- cnt_in  in  CNT_W  observed counter value
- ovf_in  in  1  observed overflow flag
- ev_valid  out  1  event record available
- ev_ready  in  1  consumer accepts record
- ev_wrap  out  WRAP_W  wrap sequence number of head record
- ev_ts  out  TS_W  timestamp of head record
- irq  out  1  sticky interrupt
- irq_clr  in  1  clear irq
- drop_cnt  out  8  events lost to full FIFO, saturating
- fifo_level  out  $clog2(DEPTH)+1  records held

## Operation
- Reset values: ev_valid=0, ev_wrap=0, ev_ts=0, irq=0, drop_cnt=0, fifo_level=0.
- Reset also clears the timestamp, the wrap sequence counter, the history registers, and prev_vld.
- Timestamp ts: free-running, increments every cycle, wraps modulo 2^TS_W.
- History:
  - cnt_q <= cnt_in and ovf_q <= ovf_in every cycle.
  - prev_vld sets 1 cycle after reset deassertion.
  - No detection while prev_vld=0.
- Wrap event: prev_vld && cnt_q == all-ones && cnt_in == 0.
  - Any other transition, including a jump to 0 from a non-max value, is not an event.
- Overflow rise: prev_vld && !ovf_q && ovf_in. It sets irq only and is not logged.
- On a wrap event:
  - Form the record {wrap_seq, ts}, where ts is the value in the detection cycle.
  - Then increment wrap_seq (mod 2^WRAP_W). It increments even when the record is dropped.
- FIFO push and pop:
  - Push when not full, or when full with a pop in the same cycle.
  - Otherwise the record is dropped and drop_cnt increments, saturating at 255.
  - Pop on ev_valid && ev_ready.
- ev_valid = fifo_level != 0. ev_wrap and ev_ts show the head record while ev_valid=1 and are held stable until popped.
- irq:
  - Set on a wrap event or an overflow rise.
  - Cleared by irq_clr.
  - Set wins when set and clear occur in the same cycle.

## Timing
- Detection is combinational on cnt_in against registered history. The push happens at the detection-cycle edge.
- A wrap visible on cnt_in in cycle N gives ev_valid=1 and irq=1 in cycle N+1 (FIFO previously empty). Latency is 1 cycle.
- The stream follows standard valid/ready rules:
  - ev_valid does not depend on ev_ready.
  - A record leaves only on a handshake.
  - Back-to-back pops are possible, one per cycle.
- Simultaneous push and pop:
  - fifo_level is unchanged.
  - When empty, push-then-pop is not a bypass: the record appears the next cycle.
- Full with a push and no pop: drop in that cycle. The FIFO contents and fifo_level are unchanged.
- Reset mid-operation:
  - All buffered records are discarded. ev_valid=0 in the cycle after the reset edge.
  - No wrap is detected in the first post-reset cycle.
- Minimum wrap spacing from a 4-bit counter is 16 cycles. The FIFO still handles an event every cycle.

## Structure
- Package counter_wrap_pkg:
  - typedef wrap_rec_t {logic [WRAP_W-1:0] seq; logic [TS_W-1:0] ts;}
  - Constant DROP_W = 8.
  - Constant DROP_MAX = 8'hFF.
- Sub-module wrap_event_fifo:
  - Synchronous FIFO of wrap_rec_t, parameter DEPTH.
  - Ports: push, push_data, pop, head, full, empty, level.
  - Internal pointers are one bit wider than the address.
- The top holds detection, timestamp, wrap_seq, irq, and drop_cnt.

## Test plan
- Reset, then count 0..15..0 with 1-cycle steps. Expected:
  - One record {seq=0, ts=detection cycle}.
  - ev_valid and irq high 1 cycle after cnt_in=0.
  - No event from the first post-reset sample even when cnt_in=0.
- Hold ev_ready=0, then force 6 wraps. Expected:
  - fifo_level=4, drop_cnt=2.
  - Drain yields seq 0,1,2,3. The next wrap yields seq=6.
- Full FIFO, with a wrap and ev_ready=1 in the same cycle. Expected: no drop, fifo_level stays 4, the new record lands at the tail.
- ovf_in 0->1 with no wrap. Expected: irq=1 and no record. irq_clr the same cycle as a new wrap leaves irq=1. irq_clr alone gives irq=0 the next cycle.
- cnt_in jumps 7->0, with no prior reset pulse in between. Expected: no record, wrap_seq unchanged.
- Reset asserted with 3 records queued. Expected: ev_valid=0, fifo_level=0, drop_cnt=0 and ts restarting at 0 the next cycle.

Source files
------------

// File: rtl/counter_wrap_pkg.sv
// Shared types and constants for the counter wrap logger.
// The event record is {wrap sequence number, timestamp}.
package counter_wrap_pkg;

  localparam int REC_WRAP_W = 8;
  localparam int REC_TS_W   = 16;
  localparam int DROP_W     = 8;

  localparam logic [DROP_W-1:0] DROP_MAX = 8'hFF;

  typedef struct packed {
    logic [REC_WRAP_W-1:0] seq;
    logic [REC_TS_W-1:0]   ts;
  } wrap_rec_t;

endpackage

// File: rtl/wrap_event_fifo.sv
// Synchronous FIFO of wrap records.
// Pointers carry an extra lap bit so full and empty are distinct.
module wrap_event_fifo
  import counter_wrap_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  wrap_rec_t push_data,
  input  logic      pop,
  output wrap_rec_t head,
  output logic      full,
  output logic      empty,
  output logic [AW:0] level
);

  wrap_rec_t   mem_q [DEPTH];
  wrap_rec_t   mem_d [DEPTH];
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push) begin
      mem_d[wr_q[AW-1:0]] = push_data;
      wr_d = wr_q + 1'b1;
    end
    if (pop) begin
      rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Head reads zero when empty so stale slots never leak out.
  always_comb begin
    level = wr_q - rd_q;
    empty = (wr_q == rd_q);
    full  = (level == (AW+1)'(DEPTH));
    head  = empty ? '0 : mem_q[rd_q[AW-1:0]];
  end

endmodule

// File: rtl/counter_wrap_logger.sv
// Detects counter wraps, logs timestamped records into a FIFO,
// and raises a sticky interrupt on wraps and overflow rises.
module counter_wrap_logger
  import counter_wrap_pkg::*;
#(
  parameter int CNT_W  = 4,
  parameter int TS_W   = REC_TS_W,
  parameter int WRAP_W = REC_WRAP_W,
  parameter int DEPTH  = 4,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CNT_W-1:0]  cnt_in,
  input  logic              ovf_in,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [WRAP_W-1:0] ev_wrap,
  output logic [TS_W-1:0]   ev_ts,
  output logic              irq,
  input  logic              irq_clr,
  output logic [DROP_W-1:0] drop_cnt,
  output logic [LW-1:0]     fifo_level
);

  logic [TS_W-1:0]   ts_q, ts_d;
  logic [WRAP_W-1:0] seq_q, seq_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              prev_vld_q, prev_vld_d;
  logic              irq_q, irq_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic      wrap_evt;
  logic      ovf_rise;
  logic      push;
  logic      pop;
  logic      full;
  logic      empty;
  wrap_rec_t rec;
  wrap_rec_t head;

  always_comb begin
    wrap_evt = prev_vld_q && (cnt_q == '1)
               && (cnt_in == '0);
    ovf_rise = prev_vld_q && !ovf_q && ovf_in;
    pop      = !empty && ev_ready;
    push     = wrap_evt && (!full || pop);
    rec.seq  = seq_q;
    rec.ts   = ts_q;
  end

  always_comb begin
    ts_d       = ts_q + 1'b1;
    cnt_d      = cnt_in;
    ovf_d      = ovf_in;
    prev_vld_d = 1'b1;
    seq_d      = seq_q;
    drop_d     = drop_q;
    irq_d      = irq_q;
    if (wrap_evt) begin
      seq_d = seq_q + 1'b1;
    end
    if (wrap_evt && !push && drop_q != DROP_MAX) begin
      drop_d = drop_q + 1'b1;
    end
    if (irq_clr) begin
      irq_d = 1'b0;
    end
    if (wrap_evt || ovf_rise) begin
      irq_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q       <= '0;
      seq_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      prev_vld_q <= 1'b0;
      irq_q      <= 1'b0;
      drop_q     <= '0;
    end else begin
      ts_q       <= ts_d;
      seq_q      <= seq_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      prev_vld_q <= prev_vld_d;
      irq_q      <= irq_d;
      drop_q     <= drop_d;
    end
  end

  wrap_event_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (rec),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  always_comb begin
    ev_valid = !empty;
    ev_wrap  = head.seq;
    ev_ts    = head.ts;
    irq      = irq_q;
    drop_cnt = drop_q;
  end

endmodule

// File: tb/tb_counter_wrap_logger.sv
// Directed and randomized checks of counter_wrap_logger
// against a queue-based reference model.
module tb_counter_wrap_logger;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cnt_in;
  logic       ovf_in;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_wrap;
  logic [15:0] ev_ts;
  logic       irq;
  logic       irq_clr;
  logic [7:0] drop_cnt;
  logic [2:0] fifo_level;

  counter_wrap_logger #(
    .CNT_W  (4),
    .TS_W   (16),
    .WRAP_W (8),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cnt_in     (cnt_in),
    .ovf_in     (ovf_in),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_wrap    (ev_wrap),
    .ev_ts      (ev_ts),
    .irq        (irq),
    .irq_clr    (irq_clr),
    .drop_cnt   (drop_cnt),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int seq;
    int ts;
  } rec_m_t;

  rec_m_t q_m[$];
  int  ts_m;
  int  seq_m;
  int  drop_m;
  bit  irq_m;
  bit  prev_m;
  int  last_cnt;
  bit  last_ovf;
  int  errors = 0;
  int  checks = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int hs;
    int ht;
    hs = (q_m.size() != 0) ? q_m[0].seq : 0;
    ht = (q_m.size() != 0) ? q_m[0].ts : 0;
    check("ev_valid", 32'(ev_valid), 32'(q_m.size() != 0));
    check("fifo_level", 32'(fifo_level), 32'(q_m.size()));
    check("ev_wrap", 32'(ev_wrap), 32'(hs));
    check("ev_ts", 32'(ev_ts), 32'(ht));
    check("irq", 32'(irq), 32'(irq_m));
    check("drop_cnt", 32'(drop_cnt), 32'(drop_m));
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic step(input bit r, input int c, input bit o,
                      input bit rdy, input bit clr);
    bit wrap;
    bit rise;
    bit pop;
    bit push;
    rec_m_t rec;
    reset    = r;
    cnt_in   = 4'(c);
    ovf_in   = o;
    ev_ready = rdy;
    irq_clr  = clr;
    if (r) begin
      q_m.delete();
      ts_m = 0; seq_m = 0; drop_m = 0;
      irq_m = 0; prev_m = 0;
      last_cnt = 0; last_ovf = 0;
    end else begin
      wrap = prev_m && last_cnt == 15 && c == 0;
      rise = prev_m && !last_ovf && o;
      pop  = (q_m.size() != 0) && rdy;
      push = 0;
      if (wrap) begin
        rec.seq = seq_m;
        rec.ts  = ts_m;
        seq_m   = (seq_m + 1) % 256;
        if (q_m.size() < DEPTH || pop) push = 1;
        else if (drop_m < 255) drop_m++;
      end
      if (pop) void'(q_m.pop_front());
      if (push) q_m.push_back(rec);
      if (clr) irq_m = 0;
      if (wrap || rise) irq_m = 1;
      ts_m = (ts_m + 1) % 65536;
      last_cnt = c;
      last_ovf = o;
      prev_m = 1;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_wrap(input bit rdy, input bit clr);
    step(0, 15, 0, rdy, 0);
    step(0, 0, 0, rdy, clr);
  endtask

  initial begin
    reset = 1; cnt_in = 0; ovf_in = 0;
    ev_ready = 0; irq_clr = 0;

    // Reset state; counter at max during reset must not fake a wrap.
    step(1, 15, 0, 0, 0);
    step(1, 15, 0, 0, 0);
    check("rst_valid", 32'(ev_valid), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    step(0, 0, 0, 0, 0);
    check("first_no_event", 32'(ev_valid), 32'd0);
    for (int i = 1; i <= 15; i++) step(0, i, 0, 0, 0);
    check("pre_wrap_irq", 32'(irq), 32'd0);
    step(0, 0, 0, 0, 0);
    check("wrap_valid", 32'(ev_valid), 32'd1);
    check("wrap_irq", 32'(irq), 32'd1);
    check("wrap_seq0", 32'(ev_wrap), 32'd0);
    check("wrap_ts", 32'(ev_ts), 32'd16);

    // Overfill with consumer stalled.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) do_wrap(0, 0);
    check("full_level", 32'(fifo_level), 32'd4);
    check("full_drops", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 4; i++) begin
      check("drain_seq", 32'(ev_wrap), 32'(i));
      step(0, 3, 0, 1, 0);
    end
    check("drained", 32'(ev_valid), 32'd0);
    do_wrap(0, 0);
    check("seq_after_drop", 32'(ev_wrap), 32'd6);

    // Full FIFO with push and pop in the same cycle.
    for (int i = 0; i < 3; i++) do_wrap(0, 0);
    check("refull", 32'(fifo_level), 32'd4);
    step(0, 15, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    check("pp_level", 32'(fifo_level), 32'd4);
    check("pp_nodrop", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 4; i++) step(0, 5, 0, 1, 0);

    // Overflow rise and irq clear priority.
    step(0, 5, 0, 0, 1);
    check("irq_cleared", 32'(irq), 32'd0);
    step(0, 5, 1, 0, 0);
    check("ovf_irq", 32'(irq), 32'd1);
    check("ovf_norec", 32'(ev_valid), 32'd0);
    step(0, 15, 1, 0, 1);
    step(0, 0, 1, 0, 1);
    check("clr_vs_wrap", 32'(irq), 32'd1);
    step(0, 2, 1, 1, 1);
    check("clr_alone", 32'(irq), 32'd0);

    // Jump to zero from a non-max value.
    step(0, 7, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    check("jump_norec", 32'(ev_valid), 32'd0);
    do_wrap(0, 0);
    check("jump_seq", 32'(ev_wrap), 32'd12);

    // Reset with records queued.
    do_wrap(0, 0);
    do_wrap(0, 0);
    check("q3", 32'(fifo_level), 32'd3);
    step(1, 0, 0, 0, 0);
    check("rst_mid_valid", 32'(ev_valid), 32'd0);
    check("rst_mid_drop", 32'(drop_cnt), 32'd0);
    for (int i = 0; i < 16; i++) step(0, i, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("rst_ts", 32'(ev_ts), 32'd16);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      int c;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 3) c = 15;
      else if (sel < 6) c = 0;
      else c = $urandom_range(0, 15);
      step($urandom_range(0, 99) == 0, c,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 7) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
